sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

SHA-256 message-schedule generator: accepts one 512-bit padded message block, then streams the 64 schedule words W0..W63, each paired with its round constant K0..K63, over a valid/ready handshake. It sits upstream of the T1 round function and supplies the Wi/Ki operands that func_t1 consumes each round. One word is delivered per accepted handshake; a full block takes 64 cycles when ready is held high.

## Interface

Parameters: none; all widths are fixed by SHA-256.

Ports:
- in_clk  input  1  rising-edge clock.
- in_rst_n  input  1  reset, synchronous, active-low.
- in_start  input  1  block-load request; sampled only in IDLE.
- in_block  input  512  padded message block, big-endian; W0 = in_block[511:480], W15 = in_block[31:0].
- out_busy  output  1  high from the cycle after load until the last word is accepted.
- out_valid  output  1  out_Wi/out_Ki/out_idx/out_last hold a valid word.
- in_ready  input  1  consumer accepts the current word when high together with out_valid.
- out_Wi  output  32  schedule word W[out_idx].
- out_Ki  output  32  round constant K[out_idx].
- out_idx  output  6  round index, 0..63.
- out_last  output  1  high while out_idx == 63 and out_valid is high.

## Operation

- States: IDLE, RUN.
- IDLE, in_start=1:
  - load w[k] = W_k (k=0..15) into a 16×32 shift register;
  - set idx=0;
  - go to RUN.
- IDLE, in_start=0: hold.
- RUN:
  - out_valid=1, out_Wi=w[0], out_Ki=K[idx].
- Handshake (out_valid && in_ready):
  - shift w[k] <= w[k+1] for k=0..14;
  - w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32;
  - idx <= idx+1.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- All additions are 32-bit with carry-out discarded.
- Handshake at idx==63: go to IDLE. idx does not wrap into a new block; the shift-register contents are don't-care afterwards.
- No handshake (in_ready=0): out_Wi, out_Ki, out_idx and out_last hold stable, and out_valid stays high. The producer never withdraws valid.
- in_start during RUN, including the cycle of the final handshake: ignored, with no effect on the stream.
- in_block is sampled only in the load cycle. Later changes to it have no effect.
- Reset (in_rst_n=0 at a clock edge), whether in IDLE or mid-block:
  - state=IDLE;
  - out_valid=0, out_busy=0, out_last=0, out_idx=0, out_Wi=0, out_Ki=0;
  - shift register cleared;
  - the partial block is discarded.

## Timing

- Load at edge N (IDLE, in_start=1): from cycle N+1, out_valid=1, out_busy=1, out_idx=0, out_Wi=W0, out_Ki=0x428a2f98.
- With in_ready held at 1: word i is presented in cycle N+1+i, and the last handshake occurs in cycle N+64.
- Cycle N+65: out_valid=0 and out_busy=0. The earliest next load is the edge ending N+65.
- Outputs are registered. Combinational paths: none from in_ready to the outputs; in_ready feeds only the state and shift enable.
- The K lookup is combinational from registered idx. W recurrence logic sits between register stages (one 4-operand adder per cycle).

## Structure

- Package sha256_pkg holds:
  - the K[0:63] constant array;
  - functions sig0/sig1 (σ0/σ1); the round-side Σ0/Σ1 functions are also placed here so func_t1 can share them;
  - the state enum {IDLE, RUN}.
- Sub-module sha256_k_rom: combinational 6-bit index to 32-bit constant, backed by the package array. It is reusable by the round engine.
- The shift register, W-update adder and FSM live in sha256_msg_sched.

## Test plan

- Empty-message block (W0=0x80000000, W1..W15=0), in_ready=1:
  - W0=0x80000000 with K0=0x428a2f98;
  - W16=0x80000000 and W17=0x00000000;
  - out_last appears only at idx 63 with K63=0xc67178f2;
  - out_valid falls exactly 64 cycles after its first assertion.
- "abc" block (W0=0x61626380, W15=0x00000018, others 0): W16=0x61626380 and W17=0x000F0000. All 64 words match a software model.
- Backpressure: drop in_ready for 3 cycles at idx=5 → out_Wi, out_idx=5 and out_Ki hold steady; the stream resumes with idx=6 and no word is skipped or duplicated.
- in_start pulsed at idx=20 with a different in_block, and again on the final handshake cycle → stream unchanged, no reload. A load one cycle later succeeds.
- in_rst_n=0 for one edge at idx=30 → the next cycle shows all outputs 0 and IDLE. A fresh load restarts at idx=0 with correct W0.
- Back-to-back blocks with in_ready=1 → the second block starts at idx=0 one idle cycle after the first block's last word.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, schedule and round-side
// sigma functions, and the message-schedule state encoding.
package sha256_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message-schedule sigmas
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Round-function sums, shared with the T1/T2 datapath
    function automatic logic [31:0] sum0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] sum1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: 6-bit round index to K constant, purely combinational.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  idx,
    output logic [31:0] k
);

    assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 512-bit block and streams W0..W63 with
// K0..K63 over valid/ready, one word per accepted handshake.
//
// state | meaning
// IDLE  | waiting for in_start; outputs invalid
// RUN   | presenting W[idx]/K[idx]; advances on each handshake, leaves after idx 63
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         in_clk,
    input  logic         in_rst_n,
    input  logic         in_start,
    input  logic [511:0] in_block,
    output logic         out_busy,
    output logic         out_valid,
    input  logic         in_ready,
    output logic [31:0]  out_Wi,
    output logic [31:0]  out_Ki,
    output logic [5:0]   out_idx,
    output logic         out_last
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] w_q [16];
    logic [5:0]  idx_q;
    logic [31:0] w_new;
    logic [31:0] k_val;
    logic        run;
    logic        hs;
    logic        load;

    assign run  = (state_q == RUN);
    assign hs   = run && in_ready;
    assign load = (state_q == IDLE) && in_start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_start) state_d = RUN;
            RUN:  if (hs && (idx_q == 6'd63)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // W[i+16] = sig1(W[i+14]) + W[i+9] + sig0(W[i+1]) + W[i], window head is W[i]
    assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            for (int k = 0; k < 16; k++) w_q[k] <= 32'h0;
            idx_q <= 6'd0;
        end else if (load) begin
            for (int k = 0; k < 16; k++) w_q[k] <= in_block[511 - 32*k -: 32];
            idx_q <= 6'd0;
        end else if (hs) begin
            for (int k = 0; k < 15; k++) w_q[k] <= w_q[k+1];
            w_q[15] <= w_new;
            idx_q   <= idx_q + 6'd1;
        end
    end

    sha256_k_rom u_k_rom (
        .idx (idx_q),
        .k   (k_val)
    );

    // K is forced to zero while idle so reset/idle outputs read all-zero
    assign out_valid = run;
    assign out_busy  = run;
    assign out_Wi    = w_q[0];
    assign out_Ki    = run ? k_val : 32'h0;
    assign out_idx   = idx_q;
    assign out_last  = run && (idx_q == 6'd63);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: hand-computed vector table plus
// directed backpressure, ignored-start, mid-block reset and back-to-back runs.
module tb_sha256_msg_sched;

    logic         in_clk;
    logic         in_rst_n;
    logic         in_start;
    logic [511:0] in_block;
    logic         out_busy;
    logic         out_valid;
    logic         in_ready;
    logic [31:0]  out_Wi;
    logic [31:0]  out_Ki;
    logic [5:0]   out_idx;
    logic         out_last;

    sha256_msg_sched dut (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_start  (in_start),
        .in_block  (in_block),
        .out_busy  (out_busy),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .out_Wi    (out_Wi),
        .out_Ki    (out_Ki),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] kt [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int          blk_id;
        int          idx;
        logic        chk_w;
        logic [31:0] w;
        logic [31:0] k;
        logic        last;
    } tvec_t;

    tvec_t       tv [10];
    logic [31:0] mw [0:63];
    logic [31:0] cap_w [0:63];
    logic [31:0] cap_k [0:63];
    logic        cap_last [0:63];
    int          n_vec;
    int          n_err;

    logic [511:0] blk_empty;
    logic [511:0] blk_abc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return m_rr(x, 7) ^ m_rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return m_rr(x, 17) ^ m_rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) mw[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            mw[i] = m_s1(mw[i-2]) + mw[i-7] + m_s0(mw[i-15]) + mw[i-16];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(out_busy),  32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_wi"},    out_Wi,         32'd0);
        chk({tag, "_ki"},    out_Ki,         32'd0);
    endtask

    // Called at a negedge with the DUT idle; block is loaded at the next posedge.
    task automatic load_block(input logic [511:0] blk);
        in_block = blk;
        in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        in_block = ~blk;
    endtask

    task automatic stream(input logic [511:0] blk, input int stall_at,
                          input int start_at, input int rst_at, output int vcyc);
        int n;
        int stalls;
        bit aborted;
        build_model(blk);
        n = 0;
        stalls = 0;
        vcyc = 0;
        aborted = 0;
        for (int cyc = 0; cyc < 200 && n < 64 && !aborted; cyc++) begin
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy",  32'(out_busy),  32'd1);
            chk("idx",   32'(out_idx),   n);
            chk("wi",    out_Wi,         mw[n]);
            chk("ki",    out_Ki,         kt[n]);
            chk("last",  32'(out_last),  32'(n == 63));
            vcyc++;
            if (n == rst_at) begin
                in_rst_n = 1'b0;
                in_ready = 1'b1;
                @(negedge in_clk);
                in_rst_n = 1'b1;
                chk_all_zero("rst_mid");
                aborted = 1;
            end else begin
                in_ready = !(n == stall_at && stalls < 3);
                if (!in_ready) stalls++;
                if (start_at >= 0 && (n == start_at || n == 63)) begin
                    in_start = 1'b1;
                    in_block = ~blk;
                end else begin
                    in_start = 1'b0;
                end
                if (in_ready) begin
                    cap_w[n]    = out_Wi;
                    cap_k[n]    = out_Ki;
                    cap_last[n] = out_last;
                    n++;
                end
                @(negedge in_clk);
            end
        end
        in_start = 1'b0;
        in_ready = 1'b1;
        if (!aborted) begin
            chk("stream_done", n, 32'd64);
            chk("end_valid", 32'(out_valid), 32'd0);
            chk("end_busy",  32'(out_busy),  32'd0);
            chk("end_last",  32'(out_last),  32'd0);
        end
    endtask

    initial begin
        int vc;
        int cur;
        n_vec = 0;
        n_err = 0;
        blk_empty = {32'h80000000, 480'd0};
        blk_abc   = {32'h61626380, 448'd0, 32'h00000018};

        tv[0] = '{0,  0, 1'b1, 32'h80000000, 32'h428a2f98, 1'b0};
        tv[1] = '{0,  1, 1'b1, 32'h00000000, 32'h71374491, 1'b0};
        tv[2] = '{0, 16, 1'b1, 32'h80000000, 32'he49b69c1, 1'b0};
        tv[3] = '{0, 17, 1'b1, 32'h00000000, 32'hefbe4786, 1'b0};
        tv[4] = '{0, 63, 1'b0, 32'h00000000, 32'hc67178f2, 1'b1};
        tv[5] = '{1,  0, 1'b1, 32'h61626380, 32'h428a2f98, 1'b0};
        tv[6] = '{1, 15, 1'b1, 32'h00000018, 32'hc19bf174, 1'b0};
        tv[7] = '{1, 16, 1'b1, 32'h61626380, 32'he49b69c1, 1'b0};
        tv[8] = '{1, 17, 1'b1, 32'h000f0000, 32'hefbe4786, 1'b0};
        tv[9] = '{1, 62, 1'b0, 32'h00000000, 32'hbef9a3f7, 1'b0};

        in_rst_n = 1'b0;
        in_start = 1'b0;
        in_ready = 1'b1;
        in_block = '0;
        @(negedge in_clk);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        chk_all_zero("reset");
        @(negedge in_clk);
        chk("idle_hold_valid", 32'(out_valid), 32'd0);

        cur = -1;
        for (int i = 0; i < 10; i++) begin
            if (tv[i].blk_id != cur) begin
                cur = tv[i].blk_id;
                load_block(cur == 0 ? blk_empty : blk_abc);
                stream(cur == 0 ? blk_empty : blk_abc, -1, -1, -1, vc);
                chk("valid_cycles", vc, 32'd64);
                @(negedge in_clk);
            end
            if (tv[i].chk_w) chk("tv_w", cap_w[tv[i].idx], tv[i].w);
            chk("tv_k",    cap_k[tv[i].idx],         tv[i].k);
            chk("tv_last", 32'(cap_last[tv[i].idx]), 32'(tv[i].last));
        end

        load_block(blk_abc);
        stream(blk_abc, 5, -1, -1, vc);
        chk("stall_valid_cycles", vc, 32'd67);

        load_block(blk_abc);
        stream(blk_abc, -1, 20, -1, vc);
        chk("start_ign_cycles", vc, 32'd64);
        load_block(blk_empty);
        stream(blk_empty, -1, -1, -1, vc);
        chk("reload_cycles", vc, 32'd64);

        load_block(blk_abc);
        stream(blk_abc, -1, -1, 30, vc);
        load_block(blk_abc);
        stream(blk_abc, -1, -1, -1, vc);
        chk("post_rst_cycles", vc, 32'd64);

        load_block(blk_empty);
        stream(blk_empty, -1, -1, -1, vc);
        load_block(blk_abc);
        stream(blk_abc, -1, -1, -1, vc);
        chk("b2b_cycles", vc, 32'd64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
